// File: rtl/cpu_types_pkg.sv
// Shared CPU types: data word, register index, memory-stage FSM states and
// the default cache-wait timeout limit.
package cpu_types_pkg;

  localparam int DATA_W             = 32;
  localparam int REG_W              = 5;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [REG_W-1:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// Memory/writeback pipeline register: captures a completing instruction's
// writeback fields; valid/regWEN/halt are pulses that drop when nothing completes.
module mem_wb_reg
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     RST,
  input  logic     load_i,
  input  logic     regwen_i,
  input  logic     halt_i,
  input  regbits_t wsel_i,
  input  word_t    wdat_i,
  output logic     wb_valid_o,
  output logic     wb_regWEN_o,
  output logic     wb_halt_o,
  output regbits_t wb_wsel_o,
  output word_t    wb_wdat_o
);

  logic     valid_q, regwen_q, halt_q;
  regbits_t wsel_q;
  word_t    wdat_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q  <= 1'b0;
      regwen_q <= 1'b0;
      halt_q   <= 1'b0;
      wsel_q   <= '0;
      wdat_q   <= '0;
    end else begin
      valid_q  <= load_i;
      regwen_q <= load_i & regwen_i;
      halt_q   <= load_i & halt_i;
      if (load_i) begin
        wsel_q <= wsel_i;
        wdat_q <= wdat_i;
      end
    end
  end

  assign wb_valid_o  = valid_q;
  assign wb_regWEN_o = regwen_q;
  assign wb_halt_o   = halt_q;
  assign wb_wsel_o   = wsel_q;
  assign wb_wdat_o   = wdat_q;

endmodule

// File: rtl/memory_stage.sv
// Memory stage: issues data-cache requests, stalls execute while waiting,
// resolves branches/jumps and feeds the writeback register.
// Optional cache-wait timeout fault is enabled by defining MEM_TIMEOUT_EN.
module memory_stage
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic     CLK,
  input  logic     RST,
  input  logic     in_valid,
  input  word_t    in_pc_plus_4,
  input  word_t    in_baddr,
  input  word_t    in_jaddr,
  input  word_t    in_portout,
  input  word_t    in_rdat2,
  input  logic     in_zero,
  input  logic     in_Branch,
  input  logic     in_bne,
  input  logic     in_Jump,
  input  logic     in_JAL,
  input  logic     in_regWEN,
  input  logic     in_MemtoReg,
  input  logic     in_dREN,
  input  logic     in_dWEN,
  input  logic     in_halt,
  input  regbits_t in_wsel,
  output logic     dREN,
  output logic     dWEN,
  output word_t    daddr,
  output word_t    dstore,
  input  logic     dhit,
  input  word_t    dload,
  output logic     ex_en,
  output logic     flush_out,
  output logic     pc_redirect,
  output word_t    pc_target,
  output logic     wb_valid,
  output logic     wb_regWEN,
  output logic     wb_halt,
  output regbits_t wb_wsel,
  output word_t    wb_wdat,
  output logic     halted,
  output logic     mem_err
);

  mem_state_t state_q, state_d;
  logic       mem_op, req, done, take_halt, br_taken, redirect;
  logic       timeout;
  word_t      wdat_sel;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       mem_err_q, mem_err_d;

  assign timeout = (state_q == WAIT) && !dhit && (cnt_q == TO_LAST);

  always_comb begin
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    if (state_q == IDLE && state_d == WAIT) begin
      cnt_d = '0;
    end else if (state_q == WAIT && !dhit) begin
      cnt_d = cnt_q + 8'd1;
    end
    if (timeout) begin
      mem_err_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign mem_err = mem_err_q;
`else
  assign timeout = 1'b0;
  assign mem_err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A halt takes priority over any memory access carried by the same instruction.
  always_comb begin
    mem_op    = in_dREN | in_dWEN;
    state_d   = state_q;
    ex_en     = 1'b1;
    req       = 1'b0;
    done      = 1'b0;
    take_halt = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_halt) begin
            take_halt = 1'b1;
            state_d   = HALTED;
          end else if (mem_op) begin
            req = 1'b1;
            if (dhit) begin
              done = 1'b1;
            end else begin
              ex_en   = 1'b0;
              state_d = WAIT;
            end
          end else begin
            done = 1'b1;
          end
        end
      end
      WAIT: begin
        req   = 1'b1;
        ex_en = 1'b0;
        if (dhit) begin
          done    = 1'b1;
          ex_en   = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        ex_en = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Execute latch is stalled while waiting, so its outputs hold the request steady.
  assign dWEN   = req & in_dWEN;
  assign dREN   = req & in_dREN & ~in_dWEN;
  assign daddr  = req ? in_portout : '0;
  assign dstore = req ? in_rdat2   : '0;

  assign br_taken    = in_Branch & (in_zero ^ in_bne);
  assign redirect    = done & (br_taken | in_Jump | in_JAL);
  assign pc_redirect = redirect;
  assign flush_out   = redirect;
  assign pc_target   = !redirect ? '0 :
                       (in_Jump | in_JAL) ? in_jaddr : in_baddr;

  assign halted = (state_q == HALTED);

  always_comb begin
    if (in_MemtoReg) begin
      wdat_sel = dload;
    end else if (in_JAL) begin
      wdat_sel = in_pc_plus_4;
    end else begin
      wdat_sel = in_portout;
    end
  end

  mem_wb_reg u_wb (
    .CLK         (CLK),
    .RST         (RST),
    .load_i      (done | take_halt),
    .regwen_i    (in_regWEN & ~take_halt),
    .halt_i      (take_halt),
    .wsel_i      (in_wsel),
    .wdat_i      (wdat_sel),
    .wb_valid_o  (wb_valid),
    .wb_regWEN_o (wb_regWEN),
    .wb_halt_o   (wb_halt),
    .wb_wsel_o   (wb_wsel),
    .wb_wdat_o   (wb_wdat)
  );

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT cycles before a timeout fault (used only under MEM_TIMEOUT_EN).
REQ-002 SHALL have ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST  in  1  reset; synchronous, active-high.
- in_valid  in  1  execute-latch outputs hold a live instruction.
- in_pc_plus_4, in_baddr, in_jaddr, in_portout, in_rdat2  in  32 each  execute-latch word outputs; in_portout is ALU result/address, in_rdat2 is store data.
- in_zero, in_Branch, in_bne, in_Jump, in_JAL, in_regWEN, in_MemtoReg, in_dREN, in_dWEN, in_halt  in  1 each  execute-latch control outputs.
- in_wsel  in  5  destination register.
- dREN, dWEN  out  1  data-cache read/write request.
- daddr, dstore  out  32  cache address and store data.
- dhit  in  1  cache completion.
- dload  in  32  cache read data, valid with dhit.
- ex_en  out  1  enable for execute latch; low = stall.
- flush_out  out  1  flush for fetch/decode latches.
- pc_redirect  out  1  PC load strobe.
- pc_target  out  32  PC load value.
- wb_valid, wb_regWEN, wb_halt  out  1 each  registered writeback controls.
- wb_wsel  out  5  registered writeback register.
- wb_wdat  out  32  registered writeback data.
- halted  out  1  sticky halt indication.
- mem_err  out  1  sticky timeout fault.

Function
REQ-003 SHALL implement FSM states IDLE, WAIT, HALTED.
REQ-004 IDLE, in_valid, in_halt: go HALTED next cycle, no cache request, wb_halt=1 with wb_valid=1 next cycle.
REQ-005 IDLE, in_valid, (in_dREN|in_dWEN): drive the request combinationally the same cycle; if dhit that cycle, complete and stay IDLE; else go WAIT with ex_en=0.
REQ-006 Both in_dREN and in_dWEN set: SHALL issue write only (dREN=0).
REQ-007 WAIT: hold dREN/dWEN/daddr/dstore stable and ex_en=0; on dhit, complete, return to IDLE, ex_en=1 that cycle.
REQ-008 Non-memory valid instruction in IDLE: complete in the same cycle.
REQ-009 daddr=in_portout, dstore=in_rdat2 whenever a request is driven; otherwise 0.
REQ-010 Completion cycle only: pc_redirect=1 if (in_Branch & (in_zero ^ in_bne)) | in_Jump | in_JAL; pc_target=in_baddr for branch, in_jaddr for Jump/JAL; flush_out=pc_redirect.
REQ-011 Completion SHALL register next cycle (1-cycle latency): wb_valid=1, wb_regWEN=in_regWEN, wb_wsel=in_wsel, wb_wdat=dload if in_MemtoReg, else in_pc_plus_4 if in_JAL, else in_portout; other cycles wb_valid=0, wb_regWEN=0.
REQ-012 dhit with no outstanding request SHALL be ignored.
REQ-013 HALTED: sticky until RST; halted=1, ex_en=0, no requests, no redirect.
REQ-014 in_valid=0 in IDLE: no request, no redirect, ex_en=1.

Reset
REQ-015 RST SHALL force IDLE next edge from any state, including mid-WAIT (request dropped next cycle).
REQ-016 After reset all registered outputs SHALL be 0 (wb_*, halted, mem_err); combinational outputs reflect IDLE with in_valid semantics.

Configuration
REQ-017 MEM_TIMEOUT_EN defined: 8-bit counter clears on entering WAIT, increments each WAIT cycle without dhit; reaching TIMEOUT_CYCLES sets mem_err, drops request, goes HALTED.
REQ-018 MEM_TIMEOUT_EN undefined: no counter; WAIT lasts indefinitely; mem_err tied 0.

Structure
REQ-019 word_t, regbits_t and the FSM state enum SHALL come from cpu_types_pkg; TIMEOUT_CYCLES default constant in the same package.
REQ-020 Writeback register bank SHALL be a sub-module mem_wb_reg; FSM and redirect logic stay in memory_stage.

Verification
REQ-021 Bench SHALL cover:
- Load, in_portout=0x100, dhit after 3 cycles, dload=0xDEADBEEF -> ex_en low 3 cycles, daddr=0x100 throughout, wb_wdat=0xDEADBEEF, wb_valid pulse 1 cycle after dhit.
- Store with same-cycle dhit, in_rdat2=0x1234 -> dWEN=1, dstore=0x1234, no stall, wb_regWEN=0.
- bne, in_zero=0, in_baddr=0x40 -> pc_redirect=1, flush_out=1, pc_target=0x40; in_zero=1 -> no redirect.
- JAL, in_jaddr=0x200, in_pc_plus_4=0x14, in_wsel=31 -> pc_target=0x200, wb_wdat=0x14, wb_wsel=31.
- RST mid-WAIT -> dREN=0 next cycle, all wb_* 0; then halt instruction -> halted=1, stays 1 under further in_valid.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, dhit never -> mem_err=1 after 4 WAIT cycles, halted=1.
